video_timing_ctrl: RTL and testbench

//  Raster timing controller that sequences the pixel generator. Produces the

---
 rtl/video_timing_ctrl.sv | 134 +++++++++++++
 tb/tb_video_timing_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: raster timing generator for one display mode.
// Produces the pixel and line counters, the video_on blanking signal,
// hsync/vsync and the line/frame start pulses. Frames start and stop only on
// frame boundaries, following the level request on run.
// Optional feature: define VTC_FRAME_CNT_EN to add the 16-bit frame_cnt output.
//
// Handshake: run is a level request. While running=0, run=1 at a clock edge
// starts a frame on the next cycle. While running=1, run is looked at only on
// the last pixel of the last line: 1 starts another frame, 0 returns to idle.
module video_timing_ctrl #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        rfr_clk,
  input  logic        reset_n,
  input  logic        run,
  output logic        running,
  output logic [11:0] pixel_cnt,
  output logic [11:0] line_cnt,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
`ifdef VTC_FRAME_CNT_EN
  , output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 13-bit compare constants so a sync window ending exactly at 4096 still decodes.
  localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_END  = 13'(V_ACTIVE);
  localparam logic [12:0] V_SYNC_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SYNC_END = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic [11:0] pix_d, line_d;
  logic [12:0] pix_x, line_x;
  logic        vo_d, hs_d, vs_d, ls_d, fs_d, act_d;

  // Next state and next raster position; run only matters in IDLE and at frame end.
  always_comb begin
    state_d = state_q;
    pix_d   = pixel_cnt;
    line_d  = line_cnt;
    case (state_q)
      IDLE: begin
        pix_d  = '0;
        line_d = '0;
        if (run) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (pixel_cnt == H_LAST) begin
          pix_d = '0;
          if (line_cnt == V_LAST) begin
            line_d = '0;
            if (!run) state_d = IDLE;
          end else begin
            line_d = line_cnt + 12'd1;
          end
        end else begin
          pix_d = pixel_cnt + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase decode of the next position, so every registered output describes the same pixel.
  always_comb begin
    act_d  = (state_d == ACTIVE);
    pix_x  = {1'b0, pix_d};
    line_x = {1'b0, line_d};
    vo_d   = act_d && (pix_x < H_ACT_END) && (line_x < V_ACT_END);
    hs_d   = (act_d && (pix_x >= H_SYNC_BEG) && (pix_x < H_SYNC_END)) ? HS_POL : ~HS_POL;
    vs_d   = (act_d && (line_x >= V_SYNC_BEG) && (line_x < V_SYNC_END)) ? VS_POL : ~VS_POL;
    ls_d   = act_d && (pix_d == 12'd0);
    fs_d   = ls_d && (line_d == 12'd0);
  end

  // State, counters and all outputs registered together; reset applies mid-frame.
  always_ff @(posedge rfr_clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pixel_cnt   <= '0;
      line_cnt    <= '0;
      running     <= 1'b0;
      video_on    <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      pixel_cnt   <= pix_d;
      line_cnt    <= line_d;
      running     <= act_d;
      video_on    <= vo_d;
      hsync       <= hs_d;
      vsync       <= vs_d;
      line_start  <= ls_d;
      frame_start <= fs_d;
    end
  end

`ifdef VTC_FRAME_CNT_EN
  // Frame counter steps in the same cycle frame_start is shown; wraps naturally.
  always_ff @(posedge rfr_clk) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if (fs_d) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Testbench for video_timing_ctrl using a reduced display mode so whole
// frames fit in a short run. Reference model tracks a linear position in the
// frame and derives pixel/line and all decodes from it arithmetically.
module tb_video_timing_ctrl;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 4;
  localparam int VA = 10, VFP = 1, VSW = 2, VBP = 3;
  localparam bit HSP = 1'b1, VSP = 1'b1;
  localparam int HT = HA + HFP + HSW + HBP;   // 25
  localparam int VT = VA + VFP + VSW + VBP;   // 16
  localparam int FRAME = HT * VT;             // 400

  typedef struct packed {
    logic        run_o;
    logic [11:0] pix;
    logic [11:0] line;
    logic        vo;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } outs_t;

  typedef struct {
    logic  r;
    logic  rn;
    outs_t exp;
  } vec_t;

  localparam outs_t IDLE_O = '{1'b0, 12'd0, 12'd0, 1'b0, !HSP, !VSP, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        running, video_on, hsync, vsync, line_start, frame_start;
  logic [11:0] pixel_cnt, line_cnt;
  outs_t       act_o;
`ifdef VTC_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // model state
  bit m_run = 1'b0;
  int m_k = 0;
  int m_frames = 0;

  video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP)
  ) dut (
    .rfr_clk    (clk),
    .reset_n    (reset_n),
    .run        (run),
    .running    (running),
    .pixel_cnt  (pixel_cnt),
    .line_cnt   (line_cnt),
    .video_on   (video_on),
    .hsync      (hsync),
    .vsync      (vsync),
    .line_start (line_start),
    .frame_start(frame_start)
`ifdef VTC_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  // clock
  always #5 clk = ~clk;

  assign act_o = {running, pixel_cnt, line_cnt, video_on, hsync, vsync, line_start, frame_start};

  // model: one edge of the raster, in terms of position within the frame
  task automatic model_edge(input logic r, input logic rn);
    if (!rn) begin
      m_run = 1'b0; m_k = 0; m_frames = 0;
    end else if (!m_run) begin
      if (r) begin
        m_run = 1'b1; m_k = 0; m_frames = (m_frames + 1) % 65536;
      end
    end else if (m_k == FRAME - 1) begin
      m_k = 0;
      if (r) m_frames = (m_frames + 1) % 65536;
      else   m_run = 1'b0;
    end else begin
      m_k = m_k + 1;
    end
  endtask

  function automatic outs_t model_out();
    outs_t o;
    int p, l;
    if (!m_run) return IDLE_O;
    p = m_k % HT;
    l = m_k / HT;
    o.run_o = 1'b1;
    o.pix   = 12'(p);
    o.line  = 12'(l);
    o.vo    = (p < HA) && (l < VA);
    o.hs    = (p >= HA + HFP && p < HA + HFP + HSW) ? HSP : !HSP;
    o.vs    = (l >= VA + VFP && l < VA + VFP + VSW) ? VSP : !VSP;
    o.ls    = (p == 0);
    o.fs    = (m_k == 0);
    return o;
  endfunction

  // driver: apply inputs, take one edge, sample 1 time unit later
  task automatic step(input logic r, input logic rn);
    run = r;
    reset_n = rn;
    @(posedge clk);
    model_edge(r, rn);
    #1;
  endtask

  // scoreboard compare
  task automatic check(input string name, input outs_t exp);
    n_vec++;
    if (act_o !== exp) begin
      n_bad++;
      $display("FAIL %s: got run=%b pix=%0d line=%0d vo=%b hs=%b vs=%b ls=%b fs=%b, expected run=%b pix=%0d line=%0d vo=%b hs=%b vs=%b ls=%b fs=%b",
               name, act_o.run_o, act_o.pix, act_o.line, act_o.vo, act_o.hs, act_o.vs, act_o.ls, act_o.fs,
               exp.run_o, exp.pix, exp.line, exp.vo, exp.hs, exp.vs, exp.ls, exp.fs);
    end
`ifdef VTC_FRAME_CNT_EN
    n_vec++;
    if (frame_cnt !== 16'(m_frames)) begin
      n_bad++;
      $display("FAIL %s_frame_cnt: got %0d expected %0d", name, frame_cnt, m_frames);
    end
`endif
  endtask

  task automatic step_chk(input logic r, input logic rn, input string name);
    step(r, rn);
    check(name, model_out());
  endtask

  // advance with checks until the model reaches (line, pix) while running
  task automatic run_until(input int l, input int p, input logic r, input string name);
    int n = 0;
    while (!(m_run && m_k == l * HT + p) && n < 3 * FRAME) begin
      step_chk(r, 1'b1, name);
      n++;
    end
    if (n >= 3 * FRAME) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: got no arrival at line %0d pixel %0d, expected arrival within %0d cycles", name, l, p, 3 * FRAME);
    end
  endtask

  vec_t tbl[6];

  initial begin
    // reset / start vectors with hand-derived expectations
    tbl[0] = '{1'b0, 1'b0, IDLE_O};
    tbl[1] = '{1'b0, 1'b1, IDLE_O};
    tbl[2] = '{1'b0, 1'b1, IDLE_O};
    tbl[3] = '{1'b1, 1'b1, '{1'b1, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}};
    tbl[4] = '{1'b0, 1'b1, '{1'b1, 12'd1, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[5] = '{1'b1, 1'b1, '{1'b1, 12'd2, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].r, tbl[i].rn);
      check($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // first frame to its end, checking blanking and sync windows on the way
    run_until(0, HA - 1, 1'b1, "last_active_px");
    step_chk(1'b1, 1'b1, "first_blank_px");
    if (video_on !== 1'b0) begin
      n_bad++;
      $display("FAIL blank_px: got video_on=%b expected 0", video_on);
    end
    n_vec++;
    run_until(VT - 1, HT - 1, 1'b1, "frame1");
    step(1'b1, 1'b1);
    check("wrap_frame", '{1'b1, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});

    // stop request mid-frame: frame completes, then idle
    run_until(5, 0, 1'b1, "pre_stop");
    run_until(VT - 1, HT - 1, 1'b0, "stopping");
    step(1'b0, 1'b1);
    check("stopped", IDLE_O);
    step(1'b0, 1'b1);
    check("idle_hold", IDLE_O);

    // stop cancelled by run returning before frame end
    step_chk(1'b1, 1'b1, "restart");
    run_until(5, 0, 1'b1, "pre_cancel");
    run_until(12, 0, 1'b0, "run_low");
    run_until(VT - 1, HT - 1, 1'b1, "run_back");
    step(1'b1, 1'b1);
    check("no_stop", '{1'b1, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});

    // run glitching freely inside frames
    for (int i = 0; i < 3 * FRAME; i++)
      step_chk(logic'($urandom_range(0, 1)), 1'b1, "glitch");

    // reset in the middle of a frame
    step_chk(1'b1, 1'b1, "pre_rst");
    run_until(3, 7, 1'b1, "to_rst_point");
    step(1'b1, 1'b0);
    check("mid_reset", IDLE_O);
    step(1'b1, 1'b1);
    check("post_reset_start", '{1'b1, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});

    // random run levels with occasional resets
    for (int i = 0; i < 2500; i++)
      step_chk(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 199) != 0), "random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
